// File: rtl/fwd_pkg.sv
// Shared encodings and types for the forwarding/hazard unit: operand-select codes,
// stall FSM states and the write-back history entry layout.
package fwd_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_MEMWB   = 2'd1;
  localparam logic [1:0] FWD_EXMEM   = 2'd2;
  localparam logic [1:0] FWD_HIST    = 2'd3;

  localparam int DEF_REG_AW = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } fsm_state_t;

  // History entry at the default pipeline geometry; the top keeps its fields as
  // parallel vectors so REG_AW/DATA_W stay free parameters.
  typedef struct packed {
    logic                  valid;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } hist_entry_t;

endpackage

// File: rtl/fwd_src_match.sv
// Per-operand forwarding select: EX/MEM > MEM/WB > youngest history hit > regfile.
// History data is driven only when the history path is chosen, otherwise zero.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DATA_W = 32,
  parameter int HIST_N = 1
) (
  input  logic [REG_AW-1:0]        i_src_addr,
  input  logic                     i_ex_mem_we,
  input  logic [REG_AW-1:0]        i_ex_mem_rd,
  input  logic                     i_mem_wb_we,
  input  logic [REG_AW-1:0]        i_mem_wb_rd,
  input  logic [HIST_N-1:0]        i_hist_valid,
  input  logic [HIST_N*REG_AW-1:0] i_hist_rd,
  input  logic [HIST_N*DATA_W-1:0] i_hist_data,
  output logic [1:0]               o_sel,
  output logic [DATA_W-1:0]        o_hist_data
);

  logic              w_src_nz;
  logic              w_hit_exmem;
  logic              w_hit_memwb;
  logic [HIST_N-1:0] w_hit_hist;

  assign w_src_nz    = (i_src_addr != '0);
  assign w_hit_exmem = w_src_nz && i_ex_mem_we && (i_ex_mem_rd == i_src_addr);
  assign w_hit_memwb = w_src_nz && i_mem_wb_we && (i_mem_wb_rd == i_src_addr);

  genvar gi;
  generate
    for (gi = 0; gi < HIST_N; gi++) begin : g_hit
      assign w_hit_hist[gi] = w_src_nz && i_hist_valid[gi] &&
                              (i_hist_rd[gi*REG_AW +: REG_AW] == i_src_addr);
    end
  endgenerate

  // Walk oldest to youngest so the youngest hit overwrites; pipeline hits override last.
  always_comb begin
    o_sel       = FWD_REGFILE;
    o_hist_data = '0;
    for (int k = HIST_N - 1; k >= 0; k--) begin
      if (w_hit_hist[k]) begin
        o_sel       = FWD_HIST;
        o_hist_data = i_hist_data[k*DATA_W +: DATA_W];
      end
    end
    if (w_hit_memwb) begin
      o_sel       = FWD_MEMWB;
      o_hist_data = '0;
    end
    if (w_hit_exmem) begin
      o_sel       = FWD_EXMEM;
      o_hist_data = '0;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: per-operand bypass selection with a short
// retired write-back history, plus a counted stall/bubble FSM for load-use hazards.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DATA_W     = 32,
  parameter int NUM_SRC    = 2,
  parameter int WB_HIST    = 1,
  parameter int LOAD_STALL = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hold_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src_addr,
  input  logic                      id_ex_mem_read,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic                      ex_mem_reg_write,
  input  logic [REG_AW-1:0]         ex_mem_rd,
  input  logic                      mem_wb_reg_write,
  input  logic [REG_AW-1:0]         mem_wb_rd,
  input  logic [DATA_W-1:0]         mem_wb_data,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0] fwd_hist_data,
  output logic                      stall_o,
  output logic                      flush_ex_o
);

  // A depth of zero still needs one (permanently invalid) slot for the match ports.
  localparam int HN = (WB_HIST > 0) ? WB_HIST : 1;
  localparam int CW = $clog2(LOAD_STALL + 1);

  logic [HN-1:0]        r_hist_valid;
  logic [HN*REG_AW-1:0] r_hist_rd;
  logic [HN*DATA_W-1:0] r_hist_data;
  logic                 w_push;

  fsm_state_t           r_state;
  fsm_state_t           w_state_next;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_next;
  logic [NUM_SRC-1:0]   w_src_hz;
  logic                 w_hz;
  logic                 w_bubble;

  assign w_push = !hold_i && mem_wb_reg_write && (mem_wb_rd != '0);

  genvar gi;
  generate
    if (WB_HIST > 0) begin : g_hist
      for (gi = 0; gi < HN; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_hist_valid[gi]                  <= 1'b0;
            r_hist_rd[gi*REG_AW +: REG_AW]    <= '0;
            r_hist_data[gi*DATA_W +: DATA_W]  <= '0;
          end else if (w_push) begin
            if (gi == 0) begin
              r_hist_valid[gi]                 <= 1'b1;
              r_hist_rd[gi*REG_AW +: REG_AW]   <= mem_wb_rd;
              r_hist_data[gi*DATA_W +: DATA_W] <= mem_wb_data;
            end else begin
              r_hist_valid[gi]                 <= r_hist_valid[gi-1];
              r_hist_rd[gi*REG_AW +: REG_AW]   <= r_hist_rd[(gi-1)*REG_AW +: REG_AW];
              r_hist_data[gi*DATA_W +: DATA_W] <= r_hist_data[(gi-1)*DATA_W +: DATA_W];
            end
          end
        end
      end
    end else begin : g_no_hist
      assign r_hist_valid = '0;
      assign r_hist_rd    = '0;
      assign r_hist_data  = '0;
    end

    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_src_match #(
        .REG_AW (REG_AW),
        .DATA_W (DATA_W),
        .HIST_N (HN)
      ) u_match (
        .i_src_addr  (ex_src_addr[gi*REG_AW +: REG_AW]),
        .i_ex_mem_we (ex_mem_reg_write),
        .i_ex_mem_rd (ex_mem_rd),
        .i_mem_wb_we (mem_wb_reg_write),
        .i_mem_wb_rd (mem_wb_rd),
        .i_hist_valid(r_hist_valid),
        .i_hist_rd   (r_hist_rd),
        .i_hist_data (r_hist_data),
        .o_sel       (fwd_sel[gi*2 +: 2]),
        .o_hist_data (fwd_hist_data[gi*DATA_W +: DATA_W])
      );

      assign w_src_hz[gi] = id_src_used[gi] &&
                            (id_src_addr[gi*REG_AW +: REG_AW] == id_ex_rd);
    end
  endgenerate

  assign w_hz = id_ex_mem_read && (id_ex_rd != '0) && (|w_src_hz);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // The IDLE cycle that detects the hazard is the first bubble; STALL covers the rest.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (!hold_i) begin
      case (r_state)
        ST_IDLE: begin
          if (w_hz && (LOAD_STALL > 1)) begin
            w_state_next = ST_STALL;
            w_cnt_next   = CW'(LOAD_STALL - 1);
          end
        end
        ST_STALL: begin
          if (r_cnt == CW'(1)) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt - CW'(1);
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_bubble   = (r_state == ST_STALL) || w_hz;
    stall_o    = rst_n && w_bubble;
    flush_ex_o = rst_n && w_bubble;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: dut_a (WB_HIST=2, LOAD_STALL=2) and dut_b (WB_HIST=1, LOAD_STALL=3)
// share all stimulus; expected values are hand-computed per step.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold_i;
  logic [9:0]  id_src_addr;
  logic [1:0]  id_src_used;
  logic [9:0]  ex_src_addr;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rd;
  logic        ex_mem_reg_write;
  logic [4:0]  ex_mem_rd;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;

  logic [3:0]  sel_a, sel_b;
  logic [63:0] hd_a, hd_b;
  logic        stall_a, stall_b, flush_a, flush_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(5), .DATA_W(32), .NUM_SRC(2), .WB_HIST(2), .LOAD_STALL(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .hold_i(hold_i),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used), .ex_src_addr(ex_src_addr),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .fwd_sel(sel_a), .fwd_hist_data(hd_a), .stall_o(stall_a), .flush_ex_o(flush_a)
  );

  fwd_hazard_unit #(.REG_AW(5), .DATA_W(32), .NUM_SRC(2), .WB_HIST(1), .LOAD_STALL(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .hold_i(hold_i),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used), .ex_src_addr(ex_src_addr),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .fwd_sel(sel_b), .fwd_hist_data(hd_b), .stall_o(stall_b), .flush_ex_o(flush_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    hold_i           = 1'b0;
    id_src_addr      = '0;
    id_src_used      = '0;
    ex_src_addr      = '0;
    id_ex_mem_read   = 1'b0;
    id_ex_rd         = '0;
    ex_mem_reg_write = 1'b0;
    ex_mem_rd        = '0;
    mem_wb_reg_write = 1'b0;
    mem_wb_rd        = '0;
    mem_wb_data      = '0;
  endtask

  // Next low phase, then settle combinational outputs.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    clear_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #2;
    // Hazard inputs active while in reset: outputs must stay low.
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd3; id_src_addr[4:0] = 5'd3; id_src_used = 2'b01;
    #1;
    chk("rst_stall_a", stall_a, 1'b0);
    chk("rst_flush_a", flush_a, 1'b0);
    chk("rst_stall_b", stall_b, 1'b0);
    chk("rst_sel_a",   sel_a,   4'd0);
    chk("rst_hd_a",    hd_a,    64'd0);
    do_reset();

    // 1: EX/MEM beats MEM/WB, MEM/WB beats history, history when both drop.
    step();
    ex_mem_reg_write = 1; ex_mem_rd = 5'd5; mem_wb_reg_write = 1; mem_wb_rd = 5'd5;
    mem_wb_data = 32'h1111; ex_src_addr[4:0] = 5'd5; #1;
    chk("t1_exmem_sel_a", sel_a[1:0], 2'd2);
    chk("t1_exmem_hd_a",  hd_a[31:0], 32'd0);
    chk("t1_exmem_sel_b", sel_b[1:0], 2'd2);
    step();
    ex_mem_reg_write = 0; #1;
    chk("t1_memwb_sel_a", sel_a[1:0], 2'd1);
    chk("t1_memwb_hd_a",  hd_a[31:0], 32'd0);
    step();
    mem_wb_reg_write = 0; #1;
    chk("t1_hist_sel_a", sel_a[1:0], 2'd3);
    chk("t1_hist_hd_a",  hd_a[31:0], 32'h1111);
    ex_mem_reg_write = 1; mem_wb_reg_write = 1; #1;
    chk("t1_all3_sel_a", sel_a[1:0], 2'd2);
    chk("t1_all3_hd_a",  hd_a[31:0], 32'd0);
    do_reset();
    ex_src_addr[4:0] = 5'd5; #1;
    chk("t1_rst_clears_hist", sel_a[1:0], 2'd0);

    // 2: register 0 never forwards and never stalls.
    step();
    clear_inputs();
    ex_mem_reg_write = 1; mem_wb_reg_write = 1; mem_wb_data = 32'hFFFF;
    id_ex_mem_read = 1; id_src_used = 2'b11; #1;
    chk("t2_sel_a",   sel_a,   4'd0);
    chk("t2_hd_a",    hd_a,    64'd0);
    chk("t2_stall_a", stall_a, 1'b0);
    chk("t2_flush_b", flush_b, 1'b0);

    // 3: pushed write-back reappears through history; hold blocks a push.
    do_reset();
    step();
    mem_wb_reg_write = 1; mem_wb_rd = 5'd7; mem_wb_data = 32'hA5A5;
    step();
    mem_wb_reg_write = 0; ex_src_addr[9:5] = 5'd7; #1;
    chk("t3_sel1_a", sel_a[3:2],  2'd3);
    chk("t3_hd1_a",  hd_a[63:32], 32'hA5A5);
    chk("t3_sel0_a", sel_a[1:0],  2'd0);
    chk("t3_hd1_b",  hd_b[63:32], 32'hA5A5);
    hold_i = 1; mem_wb_reg_write = 1; mem_wb_rd = 5'd7; mem_wb_data = 32'hBEEF;
    step();
    hold_i = 0; mem_wb_reg_write = 0; #1;
    chk("t3_hold_nopush", hd_a[63:32], 32'hA5A5);

    // 5: depth-2 history: youngest duplicate wins, oldest is evicted.
    do_reset();
    step();
    mem_wb_reg_write = 1; mem_wb_rd = 5'd4; mem_wb_data = 32'd1;
    step();
    mem_wb_data = 32'd2;
    step();
    mem_wb_reg_write = 0; ex_src_addr[4:0] = 5'd4; #1;
    chk("t5_dup_sel_a", sel_a[1:0], 2'd3);
    chk("t5_dup_hd_a",  hd_a[31:0], 32'd2);
    mem_wb_reg_write = 1; mem_wb_rd = 5'd9; mem_wb_data = 32'd3;
    step();
    mem_wb_reg_write = 0; ex_src_addr[9:5] = 5'd9; #1;
    chk("t5_rd4_sel_a", sel_a[1:0],  2'd3);
    chk("t5_rd4_hd_a",  hd_a[31:0],  32'd2);
    chk("t5_rd9_hd_a",  hd_a[63:32], 32'd3);
    chk("t5_rd4_gone_b", sel_b[1:0], 2'd0);
    mem_wb_reg_write = 1; mem_wb_rd = 5'd10; mem_wb_data = 32'd4;
    step();
    mem_wb_reg_write = 0; #1;
    chk("t5_evict_sel_a", sel_a, 4'b1100);

    // 4: load-use stall length, source-used gating, hold stretching.
    do_reset();
    step();
    id_ex_mem_read = 1; id_ex_rd = 5'd3; id_src_addr[9:5] = 5'd3; id_src_used = 2'b01; #1;
    chk("t4_unused_src", stall_a, 1'b0);
    id_src_used = 2'b10; #1;
    chk("t4_c1_stall_a", stall_a, 1'b1);
    chk("t4_c1_flush_a", flush_a, 1'b1);
    step();
    clear_inputs(); #1;
    chk("t4_c2_stall_a", stall_a, 1'b1);
    step(); #1;
    chk("t4_c3_stall_a", stall_a, 1'b0);
    chk("t4_c3_stall_b", stall_b, 1'b1);
    step(); #1;
    chk("t4_c4_stall_b", stall_b, 1'b0);
    do_reset();
    step();
    id_ex_mem_read = 1; id_ex_rd = 5'd3; id_src_addr[4:0] = 5'd3; id_src_used = 2'b01; #1;
    chk("t4h_c1_stall_a", stall_a, 1'b1);
    step();
    clear_inputs(); hold_i = 1; #1;
    chk("t4h_c2_stall_a", stall_a, 1'b1);
    step();
    hold_i = 0; #1;
    chk("t4h_c3_stall_a", stall_a, 1'b1);
    chk("t4h_c3_flush_a", flush_a, 1'b1);
    step(); #1;
    chk("t4h_c4_stall_a", stall_a, 1'b0);
    chk("t4h_c4_stall_b", stall_b, 1'b1);

    // 6: reset in the middle of a 3-bubble stall.
    do_reset();
    step();
    mem_wb_reg_write = 1; mem_wb_rd = 5'd7; mem_wb_data = 32'h55;
    step();
    mem_wb_reg_write = 0; ex_src_addr[4:0] = 5'd7;
    id_ex_mem_read = 1; id_ex_rd = 5'd3; id_src_addr[4:0] = 5'd3; id_src_used = 2'b01; #1;
    chk("t6_hist_before_b", sel_b[1:0], 2'd3);
    chk("t6_c0_stall_b",    stall_b,    1'b1);
    step();
    id_ex_mem_read = 0; id_src_used = 2'b00; #1;
    chk("t6_c1_stall_b", stall_b, 1'b1);
    rst_n = 1'b0; #1;
    chk("t6_rst_stall_b", stall_b, 1'b0);
    chk("t6_rst_flush_b", flush_b, 1'b0);
    step();
    rst_n = 1'b1; #1;
    chk("t6_hist_empty_b", sel_b[1:0], 2'd0);
    step(); #1;
    chk("t6_post1_stall_b", stall_b, 1'b0);
    step(); #1;
    chk("t6_post2_stall_b", stall_b, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
